// File: rtl/perf_section_sequencer.sv
// perf_section_sequencer
// Serialises global run/halt/clear and per-section start/stop requests onto
// the Avalon control slave of the 4-section performance counter.
// Optional feature macro: PERF_SEQ_READBACK_EN -- when defined, every section
// stop is followed by a readback of the section's 64-bit time count and
// 32-bit event count, presented as a one-cycle result record.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | arbitrate pending requests, launch the winner
// WRITE   | avm_write/begintransfer asserted for one cycle, sec_ack pulse
// RD_LO   | address 4k presented (time count, low word)
// RD_HI   | address 4k+1 presented, low word captured
// RD_EV   | address 4k+2 presented, high word captured
// RD_CAP  | event count captured, record published on the next cycle

module perf_section_sequencer #(
    parameter int NUM_SEC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        g_run,
    input  logic        g_halt,
    input  logic        g_clear,
    input  logic [2:0]  sec_start,
    input  logic [2:0]  sec_stop,
    output logic [2:0]  sec_ack,
    output logic [2:0]  sec_ovf,
    output logic        busy,
    output logic [3:0]  avm_address,
    output logic        avm_write,
    output logic        avm_begintransfer,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    output logic        res_valid,
    output logic [1:0]  res_section,
    output logic [63:0] res_time,
    output logic [31:0] res_events
);

`ifdef PERF_SEQ_READBACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_RD_LO, S_RD_HI, S_RD_EV, S_RD_CAP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE
    } state_t;
`endif

    // requester bits for sections that do not exist are dropped here
    localparam logic [2:0] SEC_MASK = 3'((1 << (NUM_SEC - 1)) - 1);

    state_t      state_q;

    // pending flags; section vectors are indexed by section number 1..3
    logic        clear_p_q, clear_p_d;
    logic        halt_p_q,  halt_p_d;
    logic        run_p_q,   run_p_d;
    logic [3:1]  start_p_q, start_p_d;
    logic [3:1]  stop_p_q,  stop_p_d;
    logic [3:1]  ovf_q,     ovf_d;
    logic [1:0]  ptr_q;

    logic [3:0]  avm_address_q;
    logic        avm_write_q;
    logic        avm_begin_q;
    logic [31:0] avm_wdata_q;
    logic [3:1]  sec_ack_q;

    logic [3:1]  start_pulse, stop_pulse;

    // arbitration results
    logic        gnt_clear, gnt_halt, gnt_run, gnt_sec, gnt_stop;
    logic [1:0]  gnt_idx;
    logic [1:0]  rr_cand;
    int          rr_idx;
    logic [3:1]  serve_start, serve_stop;
    logic        issue;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    assign start_pulse = sec_start & SEC_MASK;
    assign stop_pulse  = sec_stop  & SEC_MASK;

    // fixed-priority globals, then round-robin over sections starting at ptr_q
    always_comb begin
        gnt_clear   = 1'b0;
        gnt_halt    = 1'b0;
        gnt_run     = 1'b0;
        gnt_sec     = 1'b0;
        gnt_stop    = 1'b0;
        gnt_idx     = 2'd1;
        rr_cand     = 2'd1;
        rr_idx      = 1;
        wr_addr     = 4'd0;
        wr_data     = 32'd0;
        serve_start = 3'b000;
        serve_stop  = 3'b000;
        if (state_q == S_IDLE) begin
            if (clear_p_q) begin
                gnt_clear = 1'b1;
                wr_data   = 32'd1;
            end else if (halt_p_q) begin
                gnt_halt  = 1'b1;
            end else if (run_p_q) begin
                gnt_run   = 1'b1;
                wr_addr   = 4'd1;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (i < NUM_SEC - 1 && !gnt_sec) begin
                        rr_idx  = ((int'(ptr_q) - 1 + i) % (NUM_SEC - 1)) + 1;
                        rr_cand = 2'(rr_idx);
                        if (start_p_q[rr_cand] || stop_p_q[rr_cand]) begin
                            gnt_sec  = 1'b1;
                            gnt_idx  = rr_cand;
                            // start goes first when both are pending
                            gnt_stop = !start_p_q[rr_cand];
                        end
                    end
                end
                if (gnt_sec) begin
                    wr_addr = {gnt_idx, 1'b0, ~gnt_stop};
                    for (int k = 1; k < 4; k++) begin
                        serve_start[k] = (gnt_idx == 2'(k)) && !gnt_stop;
                        serve_stop[k]  = (gnt_idx == 2'(k)) &&  gnt_stop;
                    end
                end
            end
        end
    end

    assign issue = gnt_clear | gnt_halt | gnt_run | gnt_sec;

    // next pending state: served flags drop, new pulses set, clear wipes sections
    always_comb begin
        clear_p_d = (clear_p_q & ~gnt_clear) | g_clear;
        halt_p_d  = halt_p_q & ~gnt_halt;
        run_p_d   = run_p_q  & ~gnt_run;
        if (g_halt) begin
            halt_p_d = 1'b1;
            run_p_d  = 1'b0;
        end else if (g_run) begin
            run_p_d  = 1'b1;
            halt_p_d = 1'b0;
        end
        if (gnt_clear) begin
            start_p_d = start_pulse;
            stop_p_d  = stop_pulse;
            ovf_d     = (start_pulse & start_p_q) | (stop_pulse & stop_p_q);
        end else begin
            start_p_d = (start_p_q & ~serve_start) | start_pulse;
            stop_p_d  = (stop_p_q  & ~serve_stop)  | stop_pulse;
            ovf_d     = ovf_q
                      | (start_pulse & start_p_q & ~serve_start)
                      | (stop_pulse  & stop_p_q  & ~serve_stop);
        end
    end

    // pending flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clear_p_q <= 1'b0;
            halt_p_q  <= 1'b0;
            run_p_q   <= 1'b0;
            start_p_q <= 3'b000;
            stop_p_q  <= 3'b000;
            ovf_q     <= 3'b000;
        end else begin
            clear_p_q <= clear_p_d;
            halt_p_q  <= halt_p_d;
            run_p_q   <= run_p_d;
            start_p_q <= start_p_d;
            stop_p_q  <= stop_p_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef PERF_SEQ_READBACK_EN
    logic [1:0]  cur_sec_q;
    logic        cur_stop_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        res_valid_q;
    logic [1:0]  res_section_q;
    logic [63:0] res_time_q;
    logic [31:0] res_events_q;
`endif

    // sequencer FSM with registered bus and handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= 2'd1;
            avm_address_q <= 4'd0;
            avm_write_q   <= 1'b0;
            avm_begin_q   <= 1'b0;
            avm_wdata_q   <= 32'd0;
            sec_ack_q     <= 3'b000;
`ifdef PERF_SEQ_READBACK_EN
            cur_sec_q     <= 2'd0;
            cur_stop_q    <= 1'b0;
            lo_q          <= 32'd0;
            hi_q          <= 32'd0;
            res_valid_q   <= 1'b0;
            res_section_q <= 2'd0;
            res_time_q    <= 64'd0;
            res_events_q  <= 32'd0;
`endif
        end else begin
            avm_write_q <= 1'b0;
            avm_begin_q <= 1'b0;
            sec_ack_q   <= 3'b000;
`ifdef PERF_SEQ_READBACK_EN
            res_valid_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (issue) begin
                        state_q       <= S_WRITE;
                        avm_write_q   <= 1'b1;
                        avm_begin_q   <= 1'b1;
                        avm_address_q <= wr_addr;
                        avm_wdata_q   <= wr_data;
                        if (gnt_sec) begin
                            sec_ack_q <= serve_start | serve_stop;
                            ptr_q     <= (gnt_idx == 2'(NUM_SEC - 1)) ? 2'd1 : gnt_idx + 2'd1;
                        end
`ifdef PERF_SEQ_READBACK_EN
                        cur_sec_q  <= gnt_idx;
                        cur_stop_q <= gnt_sec & gnt_stop;
`endif
                    end
                end
                S_WRITE: begin
`ifdef PERF_SEQ_READBACK_EN
                    if (cur_stop_q) begin
                        state_q       <= S_RD_LO;
                        avm_address_q <= {cur_sec_q, 2'b00};
                    end else begin
                        state_q <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
`ifdef PERF_SEQ_READBACK_EN
                S_RD_LO: begin
                    state_q       <= S_RD_HI;
                    avm_address_q <= {cur_sec_q, 2'b01};
                end
                S_RD_HI: begin
                    state_q       <= S_RD_EV;
                    lo_q          <= avm_readdata;
                    avm_address_q <= {cur_sec_q, 2'b10};
                end
                S_RD_EV: begin
                    state_q <= S_RD_CAP;
                    hi_q    <= avm_readdata;
                end
                S_RD_CAP: begin
                    state_q       <= S_IDLE;
                    res_valid_q   <= 1'b1;
                    res_section_q <= cur_sec_q;
                    res_time_q    <= {hi_q, lo_q};
                    res_events_q  <= avm_readdata;
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sec_ack           = sec_ack_q;
    assign sec_ovf           = ovf_q;
    assign avm_address       = avm_address_q;
    assign avm_write         = avm_write_q;
    assign avm_begintransfer = avm_begin_q;
    assign avm_writedata     = avm_wdata_q;
    assign busy              = (state_q != S_IDLE) | clear_p_q | halt_p_q | run_p_q
                             | (|start_p_q) | (|stop_p_q);

`ifdef PERF_SEQ_READBACK_EN
    assign res_valid   = res_valid_q;
    assign res_section = res_section_q;
    assign res_time    = res_time_q;
    assign res_events  = res_events_q;
`else
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;
    assign res_valid   = 1'b0;
    assign res_section = 2'd0;
    assign res_time    = 64'd0;
    assign res_events  = 32'd0;
`endif

endmodule

// File: tb/tb_perf_section_sequencer.sv
// Self-checking bench for perf_section_sequencer. Expected bus writes and
// result records are queued as stimulus is applied and checked by a monitor.
module tb_perf_section_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        g_run = 1'b0, g_halt = 1'b0, g_clear = 1'b0;
    logic [2:0]  sec_start = 3'b000, sec_stop = 3'b000;
    logic [2:0]  sec_ack, sec_ovf;
    logic        busy;
    logic [3:0]  avm_address;
    logic        avm_write, avm_begintransfer;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'd0;
    logic        res_valid;
    logic [1:0]  res_section;
    logic [63:0] res_time;
    logic [31:0] res_events;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [2:0]  ack;
    } wr_t;

    typedef struct packed {
        logic [1:0]  sec;
        logic [63:0] tim;
        logic [31:0] ev;
    } res_t;

    wr_t  wr_q[$];
    res_t res_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    perf_section_sequencer #(.NUM_SEC(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .g_run(g_run), .g_halt(g_halt), .g_clear(g_clear),
        .sec_start(sec_start), .sec_stop(sec_stop),
        .sec_ack(sec_ack), .sec_ovf(sec_ovf), .busy(busy),
        .avm_address(avm_address), .avm_write(avm_write),
        .avm_begintransfer(avm_begintransfer), .avm_writedata(avm_writedata),
        .avm_readdata(avm_readdata),
        .res_valid(res_valid), .res_section(res_section),
        .res_time(res_time), .res_events(res_events)
    );

    always #5 clk = ~clk;

    // counter slave: registered readdata, word n of section k = 0x11*(n+1) + ((k-1)<<16)
    always @(posedge clk) begin
        avm_readdata <= 32'h11 * (32'(avm_address[1:0]) + 32'd1)
                      + ((32'(avm_address[3:2]) - 32'd1) << 16);
    end

    // monitor: every bus write and result record is checked against the queues
    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_write) begin
                n_cmp++;
                if (avm_begintransfer !== 1'b1) begin
                    n_bad++;
                    $display("FAIL begintransfer_with_write got=%b want=1", avm_begintransfer);
                end
                if (wr_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write addr=%0d data=%0h ack=%b", avm_address, avm_writedata, sec_ack);
                end else begin
                    wr_t e;
                    e = wr_q.pop_front();
                    n_cmp++;
                    if ({avm_address, avm_writedata, sec_ack} !== e) begin
                        n_bad++;
                        $display("FAIL write_content got addr=%0d data=%0h ack=%b want addr=%0d data=%0h ack=%b",
                                 avm_address, avm_writedata, sec_ack, e.addr, e.data, e.ack);
                    end
                end
            end else if (avm_begintransfer !== 1'b0 || sec_ack !== 3'b000) begin
                n_bad++;
                $display("FAIL strobe_outside_write begin=%b ack=%b want 0/000", avm_begintransfer, sec_ack);
            end
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_result sec=%0d time=%0h ev=%0h", res_section, res_time, res_events);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    n_cmp++;
                    if ({res_section, res_time, res_events} !== r) begin
                        n_bad++;
                        $display("FAIL result_record got sec=%0d time=%0h ev=%0h want sec=%0d time=%0h ev=%0h",
                                 res_section, res_time, res_events, r.sec, r.tim, r.ev);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [144:0] all_outputs();
        return {sec_ack, sec_ovf, busy, avm_address, avm_write, avm_begintransfer,
                avm_writedata, res_valid, res_section, res_time, res_events};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        tick();
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_idle_timeout busy=%b want 0", name, busy);
        end
        n_cmp++;
        if (wr_q.size() != 0 || res_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing_output writes_left=%0d results_left=%0d want 0/0", name, wr_q.size(), res_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (all_outputs() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%0h want 0", all_outputs());
        end
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (all_outputs() !== '0) begin
            n_bad++;
            $display("FAIL post_reset_outputs got=%0h want 0", all_outputs());
        end
    endtask

    task automatic test_run();
        wr_q.push_back('{addr: 4'd1, data: 32'd0, ack: 3'b000});
        tick();
        g_run = 1'b1;           // cycle 0
        tick();
        g_run = 1'b0;           // cycle 1
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL run_pending_busy got=%b want 1", busy);
        end
        tick();                 // cycle 2
        n_cmp++;
        if ({avm_write, avm_begintransfer, avm_address, avm_writedata} !== {1'b1, 1'b1, 4'd1, 32'd0}) begin
            n_bad++;
            $display("FAIL run_cycle2 got w=%b b=%b a=%0d d=%0h want 1 1 1 0",
                     avm_write, avm_begintransfer, avm_address, avm_writedata);
        end
        tick();                 // cycle 3
        n_cmp++;
        if (busy !== 1'b0 || avm_address !== 4'd1) begin
            n_bad++;
            $display("FAIL run_cycle3 got busy=%b addr=%0d want 0 1", busy, avm_address);
        end
        wait_idle("run");
    endtask

    task automatic test_halt_wins();
        wr_q.push_back('{addr: 4'd0, data: 32'd0, ack: 3'b000});
        g_run = 1'b1;
        g_halt = 1'b1;
        tick();
        g_run = 1'b0;
        g_halt = 1'b0;
        wait_idle("halt_wins");
    endtask

    task automatic test_start_stop();
        int res_cyc;
        wr_q.push_back('{addr: 4'd5, data: 32'd0, ack: 3'b001});
        wr_q.push_back('{addr: 4'd4, data: 32'd0, ack: 3'b001});
`ifdef PERF_SEQ_READBACK_EN
        res_q.push_back('{sec: 2'd1, tim: 64'h0000002200000011, ev: 32'h33});
`endif
        res_cyc = -1;
        sec_start = 3'b001;
        sec_stop  = 3'b001;     // cycle 0
        for (int c = 1; c <= 12; c++) begin
            tick();
            sec_start = 3'b000;
            sec_stop  = 3'b000;
            if (c == 2 || c == 4) begin
                n_cmp++;
                if (avm_write !== 1'b1 || avm_address !== ((c == 2) ? 4'd5 : 4'd4)) begin
                    n_bad++;
                    $display("FAIL start_stop_cycle%0d got w=%b a=%0d want 1 %0d",
                             c, avm_write, avm_address, (c == 2) ? 5 : 4);
                end
            end
            if (res_valid && res_cyc < 0) res_cyc = c;
        end
`ifdef PERF_SEQ_READBACK_EN
        n_cmp++;
        if (res_cyc != 9) begin
            n_bad++;
            $display("FAIL readback_latency got cycle=%0d want 9", res_cyc);
        end
        n_cmp++;
        if (res_section !== 2'd1 || res_time !== 64'h0000002200000011 || res_events !== 32'h33) begin
            n_bad++;
            $display("FAIL result_hold got sec=%0d time=%0h ev=%0h want 1 2200000011 33",
                     res_section, res_time, res_events);
        end
`endif
        wait_idle("start_stop");
    endtask

    task automatic test_round_robin();
        do_reset();
        wr_q.push_back('{addr: 4'd5,  data: 32'd0, ack: 3'b001});
        wr_q.push_back('{addr: 4'd9,  data: 32'd0, ack: 3'b010});
        wr_q.push_back('{addr: 4'd13, data: 32'd0, ack: 3'b100});
        wr_q.push_back('{addr: 4'd5,  data: 32'd0, ack: 3'b001});
        sec_start = 3'b111;     // cycle 0
        tick();
        sec_start = 3'b000;
        tick();                 // cycle 2: section 1 being written
        sec_start = 3'b001;
        tick();
        sec_start = 3'b000;
        wait_idle("round_robin");
        n_cmp++;
        if (sec_ovf !== 3'b000) begin
            n_bad++;
            $display("FAIL round_robin_ovf got=%b want 000", sec_ovf);
        end
    endtask

    task automatic test_overflow();
        wr_q.push_back('{addr: 4'd1, data: 32'd0, ack: 3'b000});
        wr_q.push_back('{addr: 4'd9, data: 32'd0, ack: 3'b010});
        g_run = 1'b1;
        sec_start = 3'b010;     // cycle 0
        tick();
        g_run = 1'b0;           // cycle 1: re-pulse while pending, run is being served
        tick();
        sec_start = 3'b000;
        wait_idle("overflow");
        n_cmp++;
        if (sec_ovf !== 3'b010) begin
            n_bad++;
            $display("FAIL overflow_sticky got=%b want 010", sec_ovf);
        end
    endtask

    task automatic test_clear();
        wr_q.push_back('{addr: 4'd0, data: 32'd1, ack: 3'b000});
        g_clear = 1'b1;
        sec_start = 3'b110;     // cycle 0
        tick();
        g_clear = 1'b0;
        sec_start = 3'b000;
        tick();
        n_cmp++;
        if (avm_write !== 1'b1 || avm_writedata !== 32'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_cycle2 got w=%b d=%0h busy=%b want 1 1 1", avm_write, avm_writedata, busy);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || sec_ovf !== 3'b000) begin
            n_bad++;
            $display("FAIL clear_flush got busy=%b ovf=%b want 0 000", busy, sec_ovf);
        end
        wait_idle("clear");
    endtask

    task automatic test_reset_mid();
        wr_q.push_back('{addr: 4'd1, data: 32'd0, ack: 3'b000});
`ifdef PERF_SEQ_READBACK_EN
        wr_q.push_back('{addr: 4'd4, data: 32'd0, ack: 3'b001});
`endif
        g_run = 1'b1;
        sec_stop = 3'b001;      // cycle 0
        tick();
        g_run = 1'b0;
        sec_stop = 3'b000;
`ifdef PERF_SEQ_READBACK_EN
        for (int c = 2; c <= 6; c++) tick();   // cycle 6 = RD_HI
`else
        for (int c = 2; c <= 3; c++) tick();   // cycle 3 = stop still pending
`endif
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pre busy=%b want 1", busy);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (all_outputs() !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs got=%0h want 0", all_outputs());
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        wait_idle("reset_mid");
    endtask

    initial begin
        test_reset();
        test_run();
        test_halt_wins();
        test_start_stop();
        test_round_robin();
        test_overflow();
        test_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/perf_section_sequencer.md
# perf_section_sequencer

Sequencer that owns the Avalon control slave of the 4-section performance counter and serialises start/stop/clear traffic from independent hardware requesters onto it. Section 0 (the global-enable section) is driven by global run/halt/clear commands; sections 1..3 are each owned by one requester. With readback compiled in, every section stop is followed by an automatic read of that section's 64-bit time count and 32-bit event count, presented as a result record.

## Interface
Parameters:
- NUM_SEC, 4, number of counter sections driven (2..4); requester bits at or above NUM_SEC are ignored.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- g_run  in  1  pulse: start section 0 (global enable)
- g_halt  in  1  pulse: stop section 0
- g_clear  in  1  pulse: global reset of all counters and enables
- sec_start  in  3  per-section start pulse; bit k-1 is section k
- sec_stop  in  3  per-section stop pulse; bit k-1 is section k
- sec_ack  out  3  one-cycle pulse when that section's write is issued
- sec_ovf  out  3  sticky: a request arrived while the same request was already pending
- busy  out  1  FSM not IDLE or any request pending
- avm_address  out  4  to counter slave address
- avm_write  out  1  to counter slave write
- avm_begintransfer  out  1  to counter slave begintransfer
- avm_writedata  out  32  to counter slave writedata
- avm_readdata  in  32  from counter slave readdata (registered in slave, 1-cycle latency)
- res_valid  out  1  one-cycle pulse: result record valid
- res_section  out  2  section index of the record
- res_time  out  64  time count of the section
- res_events  out  32  event count of the section

## Operation
- Pulses set pending flags on the next edge: run_p, halt_p, clear_p, start_p[k], stop_p[k].
- g_run and g_halt in the same cycle: halt wins, run discarded. A newer pulse clears the opposite pending global flag.
- Re-pulse of an already-pending flag: merged; sets sec_ovf[k] (sections only).
- Arbitration in IDLE, fixed order: clear_p > halt_p > run_p > sections round-robin. The round-robin pointer starts at section 1 and moves past the last section served. Within a section, start before stop.
- Writes: clear = addr 0, data 1; halt = addr 0, data 0; run = addr 1, data 0; section k stop = addr 4k, start = addr 4k+1, data 0.
- Issuing clear: all section pending flags and sec_ovf are cleared, except flags set by pulses in that same cycle.
- FSM states: IDLE -> WRITE (avm_write = avm_begintransfer = 1 for exactly one cycle; sec_ack[k] pulses in the same cycle).
  - After a start, global command, or stop without readback: WRITE -> IDLE.
  - After a stop with readback: WRITE -> RD_LO -> RD_HI -> RD_EV -> RD_CAP -> IDLE.
- Readback addresses: RD_LO 4k, RD_HI 4k+1, RD_EV 4k+2. avm_readdata is captured one cycle after each address: lo in RD_HI, hi in RD_EV, events in RD_CAP.
- res_valid pulses in the cycle after RD_CAP. Result registers hold their value until the next record.
- No start is issued during readback, so the captured 64-bit value is coherent.

## Timing
- Reset values: all outputs 0, state IDLE, pending flags 0, round-robin pointer at section 1.
- Pulse in cycle 0 -> pending flag visible in cycle 1 -> avm_write and sec_ack in cycle 2.
- Back-to-back writes: minimum 2-cycle spacing (IDLE, WRITE).
- Stop with readback: write in cycle 2, res_valid in cycle 7. IDLE arbitrates in the same cycle as res_valid.
- avm_write is never asserted outside WRITE; avm_address is held stable in every state.
- Reset asserted mid-operation: immediate return to reset values. Any in-flight readback is discarded and no res_valid is produced.

## Configuration
- PERF_SEQ_READBACK_EN defined: stop writes trigger the RD_* sequence and result records are produced.
- PERF_SEQ_READBACK_EN undefined: the RD_* states are absent and stop returns straight to IDLE. res_valid, res_section, res_time and res_events are tied to 0, and avm_readdata is unused.

## Test plan
- Reset, then g_run in cycle 0 -> cycle 2: address 1, write = begintransfer = 1, data 0. busy = 0 by cycle 3.
- sec_start[0] and sec_stop[0] in the same cycle -> write to address 5 with sec_ack[0], then a write to address 4 two cycles later. With readback: slave model returns 0x11, 0x22, 0x33 -> res_valid with section 1, res_time 0x0000002200000011, res_events 0x33.
- sec_start pulsed on sections 1, 2 and 3 together -> writes to addresses 5, 9, 13 in round-robin order. A following section-1 start is served after section 3.
- g_clear while sections 2 and 3 are pending -> single write to address 0 with data 1; pending flags and sec_ovf cleared; no further writes.
- sec_start[1] pulsed twice while pending -> one write to address 9, sec_ovf[1] = 1.
- reset_n deasserted during RD_HI -> all outputs 0 immediately; no res_valid after reset is released.
